// File: rtl/apb_spi_top_module.sv
// APB3 slave wrapping a byte-wide SPI master: register file, baud divider,
// shared tx/rx shifter and level interrupt. Master mode only, no wait states.
module apb_spi_top_module (
  input  logic       PCLK,
  input  logic       PRESET_n,
  input  logic       PSEL_i,
  input  logic       PENABLE_i,
  input  logic       PWRITE_i,
  input  logic [2:0] PADDR_i,
  input  logic [7:0] PWDATA_i,
  output logic [7:0] PRDATA_o,
  output logic       PREADY_o,
  output logic       PSLVERR_o,
  input  logic       miso_i,
  output logic       mosi_o,
  output logic       sclk_o,
  output logic       ss_o,
  output logic       spi_interrupt_request_o
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cr1_reg, cr2_reg, br_reg;
  logic [7:0]  tx_buf_reg, shifter_reg, rx_reg;
  logic        spif_reg, sptef_reg;
  logic [10:0] div_cnt_reg;
  logic [3:0]  edge_cnt_reg;
  logic        ss_reg, sclk_reg, mosi_reg, irq_reg;

  logic access, wr_en, rd_en, addr_err, modf;
  logic spie, spe, sptie, mstr, cpol, cpha, ssoe, lsbfe;
  logic dr_write_ok, dr_read;
  logic load_en, shifting, done_en;
  logic [10:0] half_period, half_m1;
  logic edge_tick, last_edge, edge_odd, sample_edge, drive_edge;

  assign access   = PSEL_i & PENABLE_i;
  assign wr_en    = access & PWRITE_i;
  assign rd_en    = access & ~PWRITE_i;
  assign addr_err = (PADDR_i == 3'd4) | (PADDR_i == 3'd6) | (PADDR_i == 3'd7);
  assign modf     = 1'b0;

  assign {spie, spe, sptie, mstr, cpol, cpha, ssoe, lsbfe} = cr1_reg;

  assign dr_write_ok = wr_en & (PADDR_i == 3'd5) & spe & mstr & sptef_reg;
  assign dr_read     = rd_en & (PADDR_i == 3'd5);

  // Half sclk period in PCLK cycles: (SPPR+1) * 2^SPR, i.e. 1..1024.
  assign half_period = {7'd0, {1'b0, br_reg[6:4]} + 4'd1} << br_reg[2:0];
  assign half_m1     = half_period - 11'd1;

  assign edge_tick   = shifting & (div_cnt_reg == half_m1);
  assign last_edge   = edge_tick & (edge_cnt_reg == 4'd15);
  assign edge_odd    = ~edge_cnt_reg[0];
  assign sample_edge = edge_tick & (cpha ? ~edge_odd : edge_odd);
  // The final edge never drives, so mosi keeps the last data bit.
  assign drive_edge  = edge_tick & (cpha ? edge_odd : ~edge_odd) & ~last_edge;

  always_ff @(posedge PCLK or posedge PRESET_n) begin
    if (PRESET_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (spe && !sptef_reg) state_next = LOAD;
      LOAD:    state_next = spe ? SHIFT : IDLE;
      SHIFT:   if (!spe) state_next = IDLE;
               else if (last_edge) state_next = DONE;
      DONE:    state_next = (spe && !sptef_reg) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_en  = (state_reg == LOAD) & spe;
    shifting = (state_reg == SHIFT) & spe;
    done_en  = (state_reg == DONE);
  end

  always_ff @(posedge PCLK or posedge PRESET_n) begin
    if (PRESET_n) begin
      cr1_reg <= 8'h04;
      cr2_reg <= 8'h00;
      br_reg  <= 8'h00;
    end else if (wr_en) begin
      case (PADDR_i)
        3'd0:    cr1_reg <= PWDATA_i;
        3'd1:    cr2_reg <= PWDATA_i & 8'h1B;
        3'd2:    br_reg  <= PWDATA_i & 8'h77;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET_n) begin
    if (PRESET_n) begin
      tx_buf_reg <= 8'h00;
      sptef_reg  <= 1'b1;
      spif_reg   <= 1'b0;
      rx_reg     <= 8'h00;
      irq_reg    <= 1'b0;
    end else begin
      if (dr_write_ok) tx_buf_reg <= PWDATA_i;
      if (load_en)          sptef_reg <= 1'b1;
      else if (dr_write_ok) sptef_reg <= 1'b0;
      // A completing transfer wins over a simultaneous DR read.
      if (done_en)                   spif_reg <= 1'b1;
      else if (dr_read && spif_reg)  spif_reg <= 1'b0;
      if (done_en) rx_reg <= shifter_reg;
      irq_reg <= (spie & (spif_reg | modf)) | (sptie & sptef_reg);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET_n) begin
    if (PRESET_n) begin
      shifter_reg  <= 8'h00;
      div_cnt_reg  <= 11'd0;
      edge_cnt_reg <= 4'd0;
      ss_reg       <= 1'b1;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
    end else if (load_en) begin
      shifter_reg  <= tx_buf_reg;
      div_cnt_reg  <= 11'd0;
      edge_cnt_reg <= 4'd0;
      ss_reg       <= ~ssoe;
      sclk_reg     <= cpol;
      mosi_reg     <= lsbfe ? tx_buf_reg[0] : tx_buf_reg[7];
    end else if (shifting) begin
      if (edge_tick) begin
        div_cnt_reg  <= 11'd0;
        edge_cnt_reg <= edge_cnt_reg + 4'd1;
        sclk_reg     <= ~sclk_reg;
        // One shifter serves both directions: sampled bits enter as sent bits leave.
        if (sample_edge)
          shifter_reg <= lsbfe ? {miso_i, shifter_reg[7:1]} : {shifter_reg[6:0], miso_i};
        if (drive_edge)
          mosi_reg <= lsbfe ? shifter_reg[0] : shifter_reg[7];
        if (last_edge)
          ss_reg <= 1'b1;
      end else begin
        div_cnt_reg <= div_cnt_reg + 11'd1;
      end
    end else begin
      ss_reg   <= 1'b1;
      sclk_reg <= cpol;
    end
  end

  always_comb begin
    PRDATA_o = 8'h00;
    if (rd_en) begin
      case (PADDR_i)
        3'd0:    PRDATA_o = cr1_reg;
        3'd1:    PRDATA_o = cr2_reg;
        3'd2:    PRDATA_o = br_reg;
        3'd3:    PRDATA_o = {spif_reg, 1'b0, sptef_reg, modf, 4'b0000};
        3'd5:    PRDATA_o = rx_reg;
        default: PRDATA_o = 8'h00;
      endcase
    end
  end

  assign PREADY_o                = access;
  assign PSLVERR_o               = access & addr_err;
  assign ss_o                    = ss_reg;
  assign sclk_o                  = sclk_reg;
  assign mosi_o                  = mosi_reg;
  assign spi_interrupt_request_o = irq_reg;

endmodule

// File: tb/tb_apb_spi_top_module.sv
// Directed bench for apb_spi_top_module: register access, address errors,
// two transfer modes, interrupt behaviour and reset during a transfer.
module tb_apb_spi_top_module;

  logic       PCLK = 1'b0;
  logic       PRESET_n = 1'b1;
  logic       PSEL_i = 1'b0, PENABLE_i = 1'b0, PWRITE_i = 1'b0;
  logic [2:0] PADDR_i = 3'd0;
  logic [7:0] PWDATA_i = 8'h00;
  logic [7:0] PRDATA_o;
  logic       PREADY_o, PSLVERR_o;
  logic       miso_i = 1'b0;
  logic       mosi_o, sclk_o, ss_o, spi_interrupt_request_o;

  int n_cmp = 0;
  int n_err = 0;

  apb_spi_top_module dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .PSEL_i(PSEL_i), .PENABLE_i(PENABLE_i), .PWRITE_i(PWRITE_i),
    .PADDR_i(PADDR_i), .PWDATA_i(PWDATA_i), .PRDATA_o(PRDATA_o),
    .PREADY_o(PREADY_o), .PSLVERR_o(PSLVERR_o),
    .miso_i(miso_i), .mosi_o(mosi_o), .sclk_o(sclk_o), .ss_o(ss_o),
    .spi_interrupt_request_o(spi_interrupt_request_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d,
                           output logic rdy, output logic err);
    @(negedge PCLK);
    PSEL_i = 1'b1; PENABLE_i = 1'b0; PWRITE_i = 1'b1; PADDR_i = a; PWDATA_i = d;
    @(negedge PCLK);
    PENABLE_i = 1'b1;
    #1;
    rdy = PREADY_o; err = PSLVERR_o;
    @(posedge PCLK);
    #1;
    PSEL_i = 1'b0; PENABLE_i = 1'b0; PWRITE_i = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d,
                          output logic rdy, output logic err);
    @(negedge PCLK);
    PSEL_i = 1'b1; PENABLE_i = 1'b0; PWRITE_i = 1'b0; PADDR_i = a;
    @(negedge PCLK);
    PENABLE_i = 1'b1;
    #1;
    d = PRDATA_o; rdy = PREADY_o; err = PSLVERR_o;
    @(posedge PCLK);
    #1;
    PSEL_i = 1'b0; PENABLE_i = 1'b0;
  endtask

  // Watches one transfer: ss low cycles, sclk edges, mosi at each odd edge.
  task automatic run_xfer(output int ss_low, output int edges,
                          output logic [7:0] mseq, output logic done);
    logic seen, prev_sclk;
    ss_low = 0; edges = 0; mseq = 8'h00; done = 1'b0; seen = 1'b0;
    prev_sclk = sclk_o;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge PCLK);
      if (ss_o == 1'b0) begin
        seen = 1'b1;
        ss_low++;
      end else if (seen) begin
        done = 1'b1;
      end
      if (sclk_o !== prev_sclk) begin
        edges++;
        if (edges % 2 == 1) mseq = {mseq[6:0], mosi_o};
        prev_sclk = sclk_o;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic rdy, err, done;
    int ss_low, edges;
    logic [7:0] mseq;
    logic [2:0] reg_addr [5];
    logic [7:0] reg_rst [5];
    logic [2:0] bad_addr [3];
    reg_addr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    reg_rst  = '{8'h04, 8'h00, 8'h00, 8'h20, 8'h00};
    bad_addr = '{3'd4, 3'd6, 3'd7};

    // Reset state of outputs
    repeat (3) @(negedge PCLK);
    check("rst_prdata", PRDATA_o, 8'h00);
    check("rst_pready", PREADY_o, 1'b0);
    check("rst_pslverr", PSLVERR_o, 1'b0);
    check("rst_ss", ss_o, 1'b1);
    check("rst_sclk", sclk_o, 1'b0);
    check("rst_mosi", mosi_o, 1'b0);
    check("rst_irq", spi_interrupt_request_o, 1'b0);
    PRESET_n = 1'b0;

    for (int i = 0; i < 5; i++) begin
      apb_read(reg_addr[i], d, rdy, err);
      check($sformatf("rst_reg%0d", reg_addr[i]), d, reg_rst[i]);
      check("rst_rd_pready", rdy, 1'b1);
      check("rst_rd_pslverr", err, 1'b0);
    end

    // Register write/readback and masking
    apb_write(3'd0, 8'hFF, rdy, err);
    check("wr_pready", rdy, 1'b1);
    apb_read(3'd0, d, rdy, err);  check("cr1_ff", d, 8'hFF);
    apb_write(3'd1, 8'h10, rdy, err);
    apb_read(3'd1, d, rdy, err);  check("cr2_10", d, 8'h10);
    apb_write(3'd2, 8'h01, rdy, err);
    apb_read(3'd2, d, rdy, err);  check("br_01", d, 8'h01);
    apb_write(3'd1, 8'hFF, rdy, err);
    apb_read(3'd1, d, rdy, err);  check("cr2_mask", d, 8'h1B);
    apb_write(3'd2, 8'hFF, rdy, err);
    apb_read(3'd2, d, rdy, err);  check("br_mask", d, 8'h77);

    // Illegal addresses
    for (int i = 0; i < 3; i++) begin
      apb_write(bad_addr[i], 8'hFF, rdy, err);
      check($sformatf("wr_err%0d", bad_addr[i]), err, 1'b1);
      apb_read(bad_addr[i], d, rdy, err);
      check($sformatf("rd_err%0d", bad_addr[i]), err, 1'b1);
      check($sformatf("rd_data%0d", bad_addr[i]), d, 8'h00);
    end
    apb_read(3'd0, d, rdy, err);  check("cr1_kept", d, 8'hFF);
    apb_read(3'd1, d, rdy, err);  check("cr2_kept", d, 8'h1B);

    // DR write with SPE=0 does nothing
    apb_write(3'd0, 8'h12, rdy, err);
    apb_write(3'd5, 8'h55, rdy, err);
    repeat (4) @(negedge PCLK);
    check("spe0_ss", ss_o, 1'b1);
    apb_read(3'd3, d, rdy, err);  check("spe0_sr", d, 8'h20);

    // Transfer CPOL=0 CPHA=0 MSB-first, D=4
    apb_write(3'd2, 8'h01, rdy, err);
    apb_write(3'd0, 8'h52, rdy, err);
    miso_i = 1'b1;
    apb_write(3'd5, 8'hA5, rdy, err);
    run_xfer(ss_low, edges, mseq, done);
    check("x0_done", done, 1'b1);
    check("x0_ss_low", ss_low, 32);
    check("x0_edges", edges, 16);
    check("x0_mosi", mseq, 8'hA5);
    check("x0_sclk_idle", sclk_o, 1'b0);
    check("x0_mosi_last", mosi_o, 1'b1);
    apb_read(3'd3, d, rdy, err);  check("x0_sr", d, 8'hA0);
    apb_read(3'd5, d, rdy, err);  check("x0_dr", d, 8'hFF);
    apb_read(3'd3, d, rdy, err);  check("x0_sr2", d, 8'h20);

    // Transfer CPOL=1 CPHA=1 LSB-first
    apb_write(3'd0, 8'h5F, rdy, err);
    @(posedge PCLK); #1;
    check("x1_sclk_idle0", sclk_o, 1'b1);
    miso_i = 1'b0;
    apb_write(3'd5, 8'hA5, rdy, err);
    run_xfer(ss_low, edges, mseq, done);
    check("x1_done", done, 1'b1);
    check("x1_ss_low", ss_low, 32);
    check("x1_edges", edges, 16);
    check("x1_mosi", mseq, 8'hA5);
    check("x1_sclk_idle1", sclk_o, 1'b1);
    apb_read(3'd3, d, rdy, err);  check("x1_sr", d, 8'hA0);
    apb_read(3'd5, d, rdy, err);  check("x1_dr", d, 8'h00);

    // Interrupt enables while idle
    apb_write(3'd0, 8'h02, rdy, err);
    repeat (2) @(negedge PCLK);
    check("irq_none", spi_interrupt_request_o, 1'b0);
    apb_write(3'd0, 8'h22, rdy, err);
    repeat (2) @(negedge PCLK);
    check("irq_sptie", spi_interrupt_request_o, 1'b1);

    // SPIE only: irq after transfer, cleared by DR read
    apb_write(3'd0, 8'hD2, rdy, err);
    miso_i = 1'b1;
    apb_write(3'd5, 8'h3C, rdy, err);
    run_xfer(ss_low, edges, mseq, done);
    check("x2_done", done, 1'b1);
    repeat (3) @(negedge PCLK);
    check("irq_spif", spi_interrupt_request_o, 1'b1);
    apb_read(3'd5, d, rdy, err);  check("x2_dr", d, 8'hFF);
    repeat (2) @(negedge PCLK);
    check("irq_cleared", spi_interrupt_request_o, 1'b0);

    // Reset in the middle of a transfer
    apb_write(3'd0, 8'hF2, rdy, err);
    apb_write(3'd5, 8'h3C, rdy, err);
    repeat (10) @(negedge PCLK);
    check("mid_ss_low", ss_o, 1'b0);
    check("mid_irq", spi_interrupt_request_o, 1'b1);
    PRESET_n = 1'b1;
    #1;
    check("abort_ss", ss_o, 1'b1);
    check("abort_irq", spi_interrupt_request_o, 1'b0);
    check("abort_sclk", sclk_o, 1'b0);
    repeat (2) @(negedge PCLK);
    PRESET_n = 1'b0;
    apb_read(3'd0, d, rdy, err);  check("post_cr1", d, 8'h04);
    apb_read(3'd3, d, rdy, err);  check("post_sr", d, 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
